// File: rtl/apb_requester.sv
// APB4 requester: turns valid/ready commands into single APB transfers
// (SETUP then ACCESS) and returns status/read data on a valid/ready response.
// Performs a local alignment check and aborts transfers that wait too long.
module apb_requester #(
    parameter  int ADDR_WIDTH     = 32,
    parameter  int DATA_WIDTH     = 32,
    parameter  int TIMEOUT_CYCLES = 16,
    localparam int STRB_WIDTH     = DATA_WIDTH / 8
) (
    input  logic                  pclk,
    input  logic                  presetn,
    // command channel
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_strb,
    input  logic [2:0]            cmd_prot,
    // response channel
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    // APB
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic [STRB_WIDTH-1:0] pstrb,
    output logic [2:0]            pprot,
    input  logic                  pready,
    input  logic                  pslverr,
    input  logic [DATA_WIDTH-1:0] prdata
);

    // Counter only needs to reach TIMEOUT_CYCLES-1; keep at least one bit.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    // Low address bits that must be zero for a full-word access.
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             misaligned;

    assign misaligned = |(cmd_addr & ALIGN_MASK);

    // Transfer sequencer; every output is a register updated on state transitions.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pstrb       <= '0;
            pprot       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        paddr     <= cmd_addr;
                        pwrite    <= cmd_write;
                        pwdata    <= cmd_wdata;
                        pstrb     <= cmd_write ? cmd_strb : '0;
                        pprot     <= cmd_prot;
                        if (misaligned) begin
                            // Rejected locally: no APB cycle is issued.
                            rsp_valid   <= 1'b1;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b0;
                            rsp_rdata   <= '0;
                            state       <= RESP;
                        end else begin
                            psel  <= 1'b1;
                            state <= SETUP;
                        end
                    end else begin
                        // Also raises ready on the first cycle out of reset.
                        cmd_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    penable  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= (!pwrite && !pslverr) ? prdata : '0;
                        state       <= RESP;
                    end else if (TIMEOUT_EN && wait_cnt == CNT_LAST) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_requester.sv
// Scoreboard bench for apb_requester: stimulus pushes expected responses and
// APB transfers into queues; independent monitors pop and compare.
module tb_apb_requester;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 16;

    logic          pclk = 1'b0;
    logic          presetn = 1'b0;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_strb;
    logic [2:0]    cmd_prot;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic          psel, penable, pwrite, pready, pslverr;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata, prdata;
    logic [SW-1:0] pstrb;
    logic [2:0]    pprot;

    always #5 pclk = ~pclk;

    apb_requester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .pready(pready), .pslverr(pslverr), .prdata(prdata)
    );

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          tmo;
        int            base;
        int            lat;
        int            hold;
    } rsp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        logic [2:0]    prot;
        int            setup_cyc;
        int            acc;
    } apb_t;

    rsp_t rsp_q[$];
    apb_t apb_q[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name, input string what);
        tests++;
        fails++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    // Completer behaviour for the current transfer.
    int            cur_waits = 0;
    logic          cur_err   = 1'b0;
    logic [DW-1:0] cur_rdata = '0;

    // Reference model: outcome of one command from the completer's plan.
    function automatic rsp_t model(input logic [AW-1:0] a, input logic w, input int waits,
                                   input logic perr, input logic [DW-1:0] prd,
                                   input int base, input int hold);
        rsp_t r;
        r.base = base;
        r.hold = hold;
        if (a[1:0] != 2'b00) begin
            r.rdata = '0; r.err = 1'b1; r.tmo = 1'b0; r.lat = 1;
        end else if (waits >= TO) begin
            r.rdata = '0; r.err = 1'b1; r.tmo = 1'b1; r.lat = 2 + TO;
        end else begin
            r.rdata = (w || perr) ? '0 : prd;
            r.err   = perr;
            r.tmo   = 1'b0;
            r.lat   = 3 + waits;
        end
        return r;
    endfunction

    // Completer: raises pready after cur_waits ACCESS cycles.
    initial begin
        int acc_cnt;
        acc_cnt = 0;
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;
        forever begin
            @(negedge pclk);
            if (psel && penable) begin
                pready = (acc_cnt == cur_waits);
                acc_cnt++;
            end else begin
                pready  = 1'b0;
                acc_cnt = 0;
            end
            pslverr = cur_err;
            prdata  = cur_rdata;
        end
    end

    // Response monitor: compares each response and holds rsp_ready low for 'hold' cycles.
    initial begin
        logic seen;
        int   held;
        rsp_t cur;
        seen = 1'b0;
        held = 0;
        cur  = '{rdata: '0, err: 1'b0, tmo: 1'b0, base: 0, lat: 0, hold: 0};
        rsp_ready = 1'b0;
        forever begin
            @(negedge pclk);
            if (!presetn) begin
                seen = 1'b0;
                rsp_ready = 1'b0;
            end else if (rsp_valid) begin
                if (!seen) begin
                    if (rsp_q.size() == 0) begin
                        fail_evt("unexpected_rsp", "got rsp_valid=1, expected no response");
                        cur = '{rdata: rsp_rdata, err: rsp_err, tmo: rsp_timeout,
                                base: 0, lat: 0, hold: 0};
                    end else begin
                        cur = rsp_q.pop_front();
                        chk("rsp_rdata",   128'(rsp_rdata),   128'(cur.rdata));
                        chk("rsp_err",     128'(rsp_err),     128'(cur.err));
                        chk("rsp_timeout", 128'(rsp_timeout), 128'(cur.tmo));
                        chk("rsp_latency", 128'(cyc - cur.base + 1), 128'(cur.lat));
                    end
                    seen = 1'b1;
                    held = 0;
                end else begin
                    chk("rsp_stable", 128'({rsp_rdata, rsp_err, rsp_timeout}),
                        128'({cur.rdata, cur.err, cur.tmo}));
                end
                chk("cmd_ready_in_resp", 128'(cmd_ready), 128'(0));
                rsp_ready = (held >= cur.hold);
                held++;
                if (rsp_ready) seen = 1'b0;
            end else begin
                rsp_ready = 1'b0;
            end
        end
    end

    // APB monitor: protocol order, setup timing, field values and stability.
    initial begin
        logic inx;
        int   accn;
        apb_t ca;
        inx  = 1'b0;
        accn = 0;
        ca   = '{addr: '0, wr: 1'b0, wdata: '0, strb: '0, prot: '0, setup_cyc: 0, acc: 0};
        forever begin
            @(negedge pclk);
            if (!presetn) begin
                inx = 1'b0;
            end else if (psel && !penable) begin
                if (apb_q.size() == 0) begin
                    fail_evt("unexpected_psel", "got psel=1, expected no APB transfer");
                    ca = '{addr: paddr, wr: pwrite, wdata: pwdata, strb: pstrb,
                           prot: pprot, setup_cyc: cyc, acc: 0};
                end else begin
                    ca = apb_q.pop_front();
                    chk("apb_setup_fields", 128'({paddr, pwrite, pwdata, pstrb, pprot}),
                        128'({ca.addr, ca.wr, ca.wdata, ca.strb, ca.prot}));
                    chk("setup_cycle", 128'(cyc), 128'(ca.setup_cyc));
                end
                inx  = 1'b1;
                accn = 0;
            end else if (psel && penable) begin
                if (!inx) fail_evt("access_without_setup", "got penable=1, expected SETUP first");
                else chk("apb_access_stable", 128'({paddr, pwrite, pwdata, pstrb, pprot}),
                         128'({ca.addr, ca.wr, ca.wdata, ca.strb, ca.prot}));
                accn++;
            end else if (penable) begin
                fail_evt("penable_without_psel", "got penable=1 psel=0, expected both 0");
            end else if (inx) begin
                chk("access_cycles", 128'(accn), 128'(ca.acc));
                inx = 1'b0;
            end
        end
    end

    // Issue one command once the requester is idle; push expectations.
    task automatic issue(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                         input logic [SW-1:0] st, input logic [2:0] pr, input int waits,
                         input logic perr, input logic [DW-1:0] prd, input int hold);
        int n;
        int e;
        apb_t ap;
        n = 0;
        @(negedge pclk);
        while (!(presetn && cmd_ready)) begin
            @(negedge pclk);
            n++;
            if (n > 200) begin
                fail_evt("cmd_ready_wait", "cmd_ready stayed 0, expected 1 within 200 cycles");
                return;
            end
        end
        cur_waits = waits;
        cur_err   = perr;
        cur_rdata = prd;
        cmd_addr  = a;
        cmd_write = w;
        cmd_wdata = wd;
        cmd_strb  = st;
        cmd_prot  = pr;
        cmd_valid = 1'b1;
        e = cyc + 1;
        rsp_q.push_back(model(a, w, waits, perr, prd, e, hold));
        if (a[1:0] == 2'b00) begin
            ap = '{addr: a, wr: w, wdata: wd, strb: w ? st : '0, prot: pr,
                   setup_cyc: e, acc: (waits >= TO) ? TO : waits + 1};
            apb_q.push_back(ap);
        end
        @(negedge pclk);
        cmd_valid = 1'b0;
        cmd_wdata = $urandom;
    endtask

    initial begin
        int n;
        logic [AW-1:0] a;
        int sel;
        int waits;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        cmd_prot  = '0;

        // Reset state
        repeat (3) @(negedge pclk);
        chk("reset_outputs", 128'({cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
                                   psel, penable, pwrite, paddr, pwdata, pstrb, pprot}), 128'(0));
        presetn = 1'b1;

        // Directed cases
        issue(32'h04, 1'b0, '0, 4'hF, 3'b000, 0, 1'b0, 32'hDEADBEEF, 0);
        issue(32'h08, 1'b1, 32'h12345678, 4'b0011, 3'b101, 2, 1'b0, 32'h0BADF00D, 0);
        issue(32'h03, 1'b0, '0, 4'hF, 3'b000, 0, 1'b0, 32'h11111111, 1);
        issue(32'h10, 1'b0, '0, 4'hF, 3'b010, 1000, 1'b0, 32'h22222222, 0);
        issue(32'h14, 1'b1, 32'hCAFEF00D, 4'b1100, 3'b001, 3, 1'b1, 32'h33333333, 5);
        issue(32'h18, 1'b0, '0, 4'hF, 3'b000, 15, 1'b0, 32'hA5A5A5A5, 0);
        issue(32'h1C, 1'b0, '0, 4'hF, 3'b000, 16, 1'b0, 32'h5A5A5A5A, 0);
        issue(32'h20, 1'b0, '0, 4'hF, 3'b000, 2, 1'b1, 32'h44444444, 0);

        // Reset during ACCESS: transfer vanishes without a response
        issue(32'h40, 1'b0, '0, 4'hF, 3'b000, 8, 1'b0, 32'h55555555, 0);
        n = 0;
        while (!(psel && penable) && n < 20) begin
            @(negedge pclk);
            n++;
        end
        if (n >= 20) fail_evt("reach_access", "never saw ACCESS, expected it within 20 cycles");
        @(negedge pclk);
        #2 presetn = 1'b0;
        #1 chk("reset_abort_apb", 128'({psel, penable, rsp_valid}), 128'(0));
        rsp_q.delete();
        apb_q.delete();
        repeat (2) @(negedge pclk);
        presetn = 1'b1;
        repeat (3) @(negedge pclk);
        chk("no_rsp_after_reset", 128'(rsp_valid), 128'(0));
        issue(32'h44, 1'b0, '0, 4'hF, 3'b000, 1, 1'b0, 32'h66666666, 0);

        // Randomized commands
        for (int i = 0; i < 60; i++) begin
            a = $urandom & 32'h0000FFFC;
            if ($urandom_range(0, 5) == 0) a = a | 32'($urandom_range(1, 3));
            sel = $urandom_range(0, 9);
            if (sel < 6)       waits = $urandom_range(0, 3);
            else if (sel == 6) waits = 15;
            else if (sel == 7) waits = 16;
            else if (sel == 8) waits = $urandom_range(4, 14);
            else               waits = 40;
            issue(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), 3'($urandom),
                  waits, 1'($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(negedge pclk);
        end

        // Drain outstanding expectations
        n = 0;
        while ((rsp_q.size() != 0 || apb_q.size() != 0 || rsp_valid) && n < 500) begin
            @(negedge pclk);
            n++;
        end
        if (n >= 500) fail_evt("drain", "expectations still pending, expected all consumed");
        repeat (2) @(negedge pclk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
